// File: rtl/deserializer_with_counter_pkg.sv
// Shared types for the serial-to-parallel receiver: the two-state FSM encoding.
package deserializer_with_counter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/deserializer_with_counter.sv
// SPI MISO deserializer: after a start pulse, shifts in DATA_LENGTH bits MSB first and
// emits each WORD_SIZE-bit word (last partial word right-aligned) with a one-cycle RCO.
module deserializer_with_counter
  import deserializer_with_counter_pkg::*;
#(
  parameter int DATA_LENGTH = 4096,
  parameter int WORD_SIZE   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 busy,
  output logic                 RCO,
  input  logic                 start,
  input  logic                 data_in
);

  localparam int BIT_W  = $clog2(DATA_LENGTH + 1);
  localparam int WORD_W = $clog2(WORD_SIZE + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_LENGTH - 1);
  localparam logic [WORD_W-1:0] LAST_WBIT = WORD_W'(WORD_SIZE - 1);

  state_t                 state, state_n;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_n;
  logic [WORD_W-1:0]      word_cnt, word_cnt_n;
  logic [WORD_SIZE-1:0]   shift_reg, shift_reg_n;
  logic [WORD_SIZE-1:0]   data_out_n;
  logic                   rco_n;
  logic [WORD_SIZE-1:0]   shifted;

  // Shift-left form stays legal when WORD_SIZE == 1.
  assign shifted = (shift_reg << 1) | WORD_SIZE'(data_in);
  assign busy    = (state == ST_SHIFT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      RCO       <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      word_cnt  <= word_cnt_n;
      shift_reg <= shift_reg_n;
      data_out  <= data_out_n;
      RCO       <= rco_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    word_cnt_n  = word_cnt;
    shift_reg_n = shift_reg;
    data_out_n  = data_out;
    rco_n       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n     = ST_SHIFT;
          bit_cnt_n   = '0;
          word_cnt_n  = '0;
          shift_reg_n = '0;
        end
      end
      ST_SHIFT: begin
        shift_reg_n = shifted;
        bit_cnt_n   = bit_cnt + BIT_W'(1);
        word_cnt_n  = word_cnt + WORD_W'(1);
        // Clearing the shifter at each word boundary leaves a short final word
        // right-aligned with zero upper bits, so it can be presented as-is.
        if (word_cnt == LAST_WBIT || bit_cnt == LAST_BIT) begin
          data_out_n  = shifted;
          rco_n       = 1'b1;
          word_cnt_n  = '0;
          shift_reg_n = '0;
        end
        if (bit_cnt == LAST_BIT) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_deserializer_with_counter.sv
// Self-checking bench: three receiver instances (16/8, 7/8, 4096/8) with a per-instance
// expected-word queue popped on every RCO strobe.
module tb_deserializer_with_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic       start16, din16, busy16, rco16;
  logic [7:0] dout16;
  logic       start7, din7, busy7, rco7;
  logic [7:0] dout7;
  logic       startd, dind, busyd, rcod;
  logic [7:0] doutd;

  deserializer_with_counter #(.DATA_LENGTH(16), .WORD_SIZE(8)) dut16 (
    .clock(clock), .reset(reset), .data_out(dout16), .busy(busy16),
    .RCO(rco16), .start(start16), .data_in(din16));

  deserializer_with_counter #(.DATA_LENGTH(7), .WORD_SIZE(8)) dut7 (
    .clock(clock), .reset(reset), .data_out(dout7), .busy(busy7),
    .RCO(rco7), .start(start7), .data_in(din7));

  deserializer_with_counter dutd (
    .clock(clock), .reset(reset), .data_out(doutd), .busy(busyd),
    .RCO(rcod), .start(startd), .data_in(dind));

  int n_vec = 0;
  int n_err = 0;
  int rcod_cnt = 0;
  logic [7:0] exp16_q[$];
  logic [7:0] exp7_q[$];
  logic [7:0] expd_q[$];

  typedef struct {
    logic [15:0] stream;
    int          glitch_at;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitors: every strobe must match the head of its queue.
  always @(negedge clock) begin
    if (reset === 1'b1 && rco16 === 1'b1) begin
      if (exp16_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rco16_unexpected: got strobe with data_out %0h, expected none", dout16);
      end else check("rco16_word", {24'd0, dout16}, {24'd0, exp16_q.pop_front()});
    end
  end

  always @(negedge clock) begin
    if (reset === 1'b1 && rco7 === 1'b1) begin
      if (exp7_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rco7_unexpected: got strobe with data_out %0h, expected none", dout7);
      end else check("rco7_word", {24'd0, dout7}, {24'd0, exp7_q.pop_front()});
    end
  end

  always @(negedge clock) begin
    if (reset === 1'b1 && rcod === 1'b1) begin
      rcod_cnt++;
      if (expd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rcod_unexpected: got strobe with data_out %0h, expected none", doutd);
      end else check("rcod_word", {24'd0, doutd}, {24'd0, expd_q.pop_front()});
    end
  end

  // One 16-bit transfer; start is asserted in the first cycle found idle.
  task automatic xfer16(input logic [15:0] stream, input int glitch,
                        input logic [7:0] hi, input logic [7:0] lo);
    int busy_seen;
    busy_seen = 0;
    @(negedge clock);
    check("busy16_idle_before_start", {31'd0, busy16}, 32'd0);
    exp16_q.push_back(hi);
    exp16_q.push_back(lo);
    start16 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      start16 = (i == glitch);
      din16   = stream[15-i];
      if (busy16) busy_seen++;
    end
    start16 = 1'b0;
    check("busy16_cycles", busy_seen, 32'd16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    logic [6:0] pat7;
    logic [7:0] byte_v;
    logic [15:0] rst_stream;

    vecs[0] = '{16'hA53C, -1, 8'hA5, 8'h3C};
    vecs[1] = '{16'hFF00,  5, 8'hFF, 8'h00};
    vecs[2] = '{16'h0001, -1, 8'h00, 8'h01};
    vecs[3] = '{16'h8000,  5, 8'h80, 8'h00};
    vecs[4] = '{16'h5AC3,  0, 8'h5A, 8'hC3};

    reset = 1'b0;
    start16 = 1'b0; din16 = 1'b0;
    start7  = 1'b0; din7  = 1'b0;
    startd  = 1'b0; dind  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy16", {31'd0, busy16}, 32'd0);
    check("reset_rco16", {31'd0, rco16}, 32'd0);
    check("reset_dout16", {24'd0, dout16}, 32'd0);
    check("reset_busyd", {31'd0, busyd}, 32'd0);
    check("reset_doutd", {24'd0, doutd}, 32'd0);
    reset = 1'b1;

    // Table vectors run back-to-back; some re-pulse start mid-transfer.
    for (int v = 0; v < 5; v++) begin
      xfer16(vecs[v].stream, vecs[v].glitch_at, vecs[v].exp_hi, vecs[v].exp_lo);
    end
    @(negedge clock);
    check("busy16_fall", {31'd0, busy16}, 32'd0);
    check("dout16_hold_after", {24'd0, dout16}, 32'h0000_00C3);

    // Idle with data_in toggling: nothing may move.
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      din16 = $urandom_range(0, 1);
      start16 = 1'b0;
      if (busy16 || rco16) busy_seen++;
    end
    check("idle_no_activity", busy_seen, 32'd0);
    check("idle_dout16_hold", {24'd0, dout16}, 32'h0000_00C3);

    // Reset after 11 bits aborts; only the first word is ever strobed.
    rst_stream = 16'hA5FF;
    @(negedge clock);
    exp16_q.push_back(8'hA5);
    start16 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      start16 = 1'b0;
      din16 = rst_stream[15-i];
    end
    @(negedge clock);
    check("pre_reset_dout16", {24'd0, dout16}, 32'h0000_00A5);
    reset = 1'b0;
    @(negedge clock);
    check("midreset_busy16", {31'd0, busy16}, 32'd0);
    check("midreset_rco16", {31'd0, rco16}, 32'd0);
    check("midreset_dout16", {24'd0, dout16}, 32'd0);
    reset = 1'b1;
    xfer16(16'h3CA5, -1, 8'h3C, 8'hA5);
    @(negedge clock);
    check("post_reset_busy16_fall", {31'd0, busy16}, 32'd0);

    // Short transfer: 7 bits into an 8-bit word, right-aligned.
    pat7 = 7'b1010101;
    @(negedge clock);
    check("busy7_idle", {31'd0, busy7}, 32'd0);
    exp7_q.push_back(8'h55);
    start7 = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      start7 = 1'b0;
      din7 = pat7[6-i];
      if (busy7) busy_seen++;
    end
    check("busy7_cycles", busy_seen, 32'd7);
    @(negedge clock);
    check("busy7_fall", {31'd0, busy7}, 32'd0);
    check("dout7_final", {24'd0, dout7}, 32'h0000_0055);

    // Default 4096-bit block of bytes i mod 256.
    @(negedge clock);
    check("busyd_idle", {31'd0, busyd}, 32'd0);
    for (int b = 0; b < 512; b++) expd_q.push_back(8'(b));
    startd = 1'b1;
    busy_seen = 0;
    for (int b = 0; b < 512; b++) begin
      byte_v = 8'(b);
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        startd = 1'b0;
        dind = byte_v[7-i];
        if (busyd) busy_seen++;
      end
    end
    check("busyd_cycles", busy_seen, 32'd4096);
    @(negedge clock);
    check("busyd_fall", {31'd0, busyd}, 32'd0);
    @(negedge clock);
    check("rcod_count", rcod_cnt, 32'd512);
    check("doutd_final", {24'd0, doutd}, 32'h0000_00FF);

    repeat (3) @(negedge clock);
    check("exp16_q_drained", exp16_q.size(), 32'd0);
    check("exp7_q_drained", exp7_q.size(), 32'd0);
    check("expd_q_drained", expd_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
